// File: rtl/display_feed_if.sv
// Bundle of CPU debug bytes, raw board controls and scanner-facing outputs for display_feed.
interface display_feed_if;
    logic        btn_step;
    logic [1:0]  sw_sel;
    logic [31:0] cur_pc;
    logic [31:0] next_pc;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] alu_result;
    logic [31:0] db_data;
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic [1:0]  page;
    logic        scan_clk;
    logic        step_pulse;

    modport master (
        output btn_step, sw_sel, cur_pc, next_pc, rs_addr, rt_addr,
               rs_data, rt_data, alu_result, db_data,
        input  in1, in2, page, scan_clk, step_pulse
    );

    modport slave (
        input  btn_step, sw_sel, cur_pc, next_pc, rs_addr, rt_addr,
               rs_data, rt_data, alu_result, db_data,
        output in1, in2, page, scan_clk, step_pulse
    );
endinterface

// File: rtl/display_feed.sv
// Seven-segment feeder: page mux of CPU bytes, scan clock divider and
// single-step button debouncer producing a one-cycle step pulse.
module display_feed #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SCAN_DIV        = 100000
) (
    input logic         clk,
    input logic         rst_n,
    display_feed_if.slave bus
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic              btn_s1, btn_s2;
    logic [1:0]        sel_s1, sel_s2;
    logic [7:0]        in1_q, in2_q;
    logic [1:0]        page_q;
    logic [SCAN_W-1:0] scan_cnt_q;
    logic              scan_clk_q;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pulse_q, pulse_d;

    // Only the low byte of each CPU word is shown on the display.
    logic unused_bits;
    assign unused_bits = ^{bus.cur_pc[31:8], bus.next_pc[31:8], bus.rs_data[31:8],
                           bus.rt_data[31:8], bus.alu_result[31:8], bus.db_data[31:8]};

    // Two-flop synchronizers for the asynchronous board controls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            sel_s1 <= 2'b00;
            sel_s2 <= 2'b00;
        end else begin
            btn_s1 <= bus.btn_step;
            btn_s2 <= btn_s1;
            sel_s1 <= bus.sw_sel;
            sel_s2 <= sel_s1;
        end
    end

    // Page mux; page is registered from the same select so it matches in1/in2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in1_q  <= 8'h00;
            in2_q  <= 8'h00;
            page_q <= 2'b00;
        end else begin
            page_q <= sel_s2;
            case (sel_s2)
                2'b00: begin
                    in1_q <= bus.cur_pc[7:0];
                    in2_q <= bus.next_pc[7:0];
                end
                2'b01: begin
                    in1_q <= {3'b000, bus.rs_addr};
                    in2_q <= bus.rs_data[7:0];
                end
                2'b10: begin
                    in1_q <= {3'b000, bus.rt_addr};
                    in2_q <= bus.rt_data[7:0];
                end
                default: begin
                    in1_q <= bus.alu_result[7:0];
                    in2_q <= bus.db_data[7:0];
                end
            endcase
        end
    end

    // Scan divider: toggle scan_clk every SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            scan_clk_q <= 1'b0;
        end else if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            scan_clk_q <= ~scan_clk_q;
        end else begin
            scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
        end
    end

    // Debounce state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // Debounce next state; pulse only on the PRESS_WAIT -> PRESSED transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s2) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s2) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s2) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s2) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.in1        = in1_q;
    assign bus.in2        = in2_q;
    assign bus.page       = page_q;
    assign bus.scan_clk   = scan_clk_q;
    assign bus.step_pulse = pulse_q;

endmodule

// File: tb/tb_display_feed.sv
// Directed bench for display_feed with DEBOUNCE_CYCLES=4, SCAN_DIV=3.
module tb_display_feed;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   n;            // edges since last reset edge
    int   pulse_edge;   // edge number at which step_pulse must be high, -1 for none

    display_feed_if bus ();

    display_feed #(
        .DEBOUNCE_CYCLES(4),
        .SCAN_DIV(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then check scan clock and step pulse against the edge model.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst_n) n = 0;
        else        n++;
        chk("scan_clk", 32'(bus.scan_clk), 32'((n / 3) % 2));
        chk("step_pulse", 32'(bus.step_pulse), 32'(n == pulse_edge));
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic chk_bytes(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                             input logic [1:0] ep);
        chk({tag, "_in1"}, 32'(bus.in1), 32'(e1));
        chk({tag, "_in2"}, 32'(bus.in2), 32'(e2));
        chk({tag, "_page"}, 32'(bus.page), 32'(ep));
    endtask

    initial begin
        logic [7:0] pat_bounce [8];
        logic [7:0] pat_short [5];
        int         m;

        errors     = 0;
        checks     = 0;
        n          = 0;
        pulse_edge = -1;

        // Test 1: reset with every input nonzero
        rst_n              = 1'b0;
        bus.btn_step       = 1'b1;
        bus.sw_sel         = 2'b11;
        bus.cur_pc         = 32'h0000_0014;
        bus.next_pc        = 32'h0000_0018;
        bus.rs_addr        = 5'h1F;
        bus.rs_data        = 32'h0000_00AB;
        bus.rt_addr        = 5'h02;
        bus.rt_data        = 32'h0000_00CD;
        bus.alu_result     = 32'h0000_003C;
        bus.db_data        = 32'h0000_0077;
        ticks(3);
        chk_bytes("reset", 8'h00, 8'h00, 2'b00);

        rst_n        = 1'b1;
        bus.btn_step = 1'b0;
        bus.sw_sel   = 2'b00;
        ticks(9);

        // Test 2: page mux, two-edge select latency
        chk_bytes("page0", 8'h14, 8'h18, 2'b00);
        bus.sw_sel = 2'b01;
        ticks(2);
        chk_bytes("page1_lat", 8'h14, 8'h18, 2'b00);
        tick();
        chk_bytes("page1", 8'h1F, 8'hAB, 2'b01);
        bus.sw_sel = 2'b10;
        ticks(2);
        chk_bytes("page2_lat", 8'h1F, 8'hAB, 2'b01);
        tick();
        chk_bytes("page2", 8'h02, 8'hCD, 2'b10);
        bus.sw_sel = 2'b11;
        ticks(3);
        chk_bytes("page3", 8'h3C, 8'h77, 2'b11);
        bus.alu_result = 32'hFFFF_FF5A;
        tick();
        chk_bytes("data_lat", 8'h5A, 8'h77, 2'b11);

        // Test 3: clean press gives one pulse six edges after first sampling
        m            = n;
        bus.btn_step = 1'b1;
        pulse_edge   = m + 7;
        ticks(20);
        bus.btn_step = 1'b0;
        pulse_edge   = -1;
        ticks(20);

        // Test 4a: bounce during qualification restarts it
        pat_bounce = '{8'd1, 8'd1, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        m          = n;
        pulse_edge = m + 10;
        for (int i = 0; i < 8; i++) begin
            bus.btn_step = pat_bounce[i][0];
            tick();
        end
        ticks(12);
        bus.btn_step = 1'b0;
        pulse_edge   = -1;
        ticks(20);

        // Test 4b: short high/low/high never qualifies
        pat_short = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd0};
        for (int i = 0; i < 5; i++) begin
            bus.btn_step = pat_short[i][0];
            tick();
        end
        bus.btn_step = 1'b0;
        ticks(12);

        // Test 5: release glitch returns to PRESSED without a second pulse
        m            = n;
        bus.btn_step = 1'b1;
        pulse_edge   = m + 7;
        ticks(12);
        bus.btn_step = 1'b0;
        ticks(2);
        bus.btn_step = 1'b1;
        ticks(20);
        bus.btn_step = 1'b0;
        pulse_edge   = -1;
        ticks(20);

        // Test 6: reset during PRESS_WAIT (cnt=2) while scan_clk is high
        for (int i = 0; i < 6; i++) begin
            if (((n + 5) / 3) % 2 == 1) break;
            tick();
        end
        chk("align_scan", 32'(((n + 5) / 3) % 2), 32'd1);
        bus.btn_step = 1'b1;
        ticks(5);
        chk("mid_scan_hi", 32'(bus.scan_clk), 32'd1);
        rst_n = 1'b0;
        tick();
        chk_bytes("mid_reset", 8'h00, 8'h00, 2'b00);
        rst_n      = 1'b1;
        pulse_edge = 7;
        ticks(14);
        chk_bytes("post_reset", 8'h5A, 8'h77, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
